// File: rtl/imap_stream_biu.sv
// Input-feature-map stream BIU: issues credit-limited bus reads and forwards in-order
// responses to the MAC imap buffer. Define IMAP_STREAM_BIU_ADDR_CHK_EN for response address checking.
module imap_stream_biu #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_OSTD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imap_start,
    output logic              imap_done,
    output logic              imap_busy,
    input  logic [7:0]        in_ch,
    input  logic [15:0]       map_size,
    input  logic [ADDR_W-1:0] imap_base_addr,
    output logic              imap_biu2arb_req,
    output logic [ADDR_W-1:0] imap_biu2arb_addr,
    output logic              imap_biu2arb_vld,
    input  logic              imap_biu2arb_rdy,
    input  logic [ADDR_W-1:0] arb2imap_biu_addr,
    input  logic [DATA_W-1:0] arb2imap_biu_data,
    input  logic              arb2imap_biu_vld,
    output logic              arb2imap_biu_rdy,
    output logic [23:0]       imap_waddr,
    output logic [DATA_W-1:0] imap_wdata,
    output logic              imap_wen,
    input  logic              imap_wrdy,
    output logic              imap_err
);
    localparam int PW = $clog2(MAX_OSTD);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [23:0]       total, iss_cnt, start_total;
    logic [CW-1:0]     credit, credit_nxt, fifo_cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_mem [MAX_OSTD];
    logic              start_acc, addr_hs, push, pop, fifo_full, fifo_empty;
    logic              draining, last_addr, last_write;

    assign start_total = 24'(in_ch) * 24'(map_size);
    assign start_acc   = imap_start && (state == IDLE);
    assign addr_hs     = imap_biu2arb_vld && imap_biu2arb_rdy;
    assign draining    = (state == RUN) || (state == DRAIN);
    assign fifo_full   = (fifo_cnt == CW'(MAX_OSTD));
    assign fifo_empty  = (fifo_cnt == '0);

    // Outside RUN/DRAIN responses are always accepted and dropped (late data after reset).
    assign arb2imap_biu_rdy = draining ? !fifo_full : 1'b1;
    assign push       = arb2imap_biu_vld && arb2imap_biu_rdy && draining;
    assign imap_wen   = !fifo_empty;
    assign imap_wdata = fifo_mem[rd_ptr];
    assign pop        = imap_wen && imap_wrdy;
    assign last_addr  = addr_hs && (iss_cnt == total - 24'd1);
    assign last_write = pop && (imap_waddr == total - 24'd1);
    assign credit_nxt = credit + CW'(addr_hs) - CW'(pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = (start_total == '0) ? DONE : RUN;
            RUN:     if (last_addr) state_nxt = DRAIN;
            DRAIN:   if (last_write) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            credit            <= '0;
            total             <= '0;
            iss_cnt           <= '0;
            imap_busy         <= 1'b0;
            imap_done         <= 1'b0;
            imap_biu2arb_req  <= 1'b0;
            imap_biu2arb_vld  <= 1'b0;
            imap_biu2arb_addr <= '0;
            imap_waddr        <= '0;
        end else begin
            state            <= state_nxt;
            credit           <= credit_nxt;
            imap_busy        <= (state_nxt != IDLE);
            imap_done        <= (state_nxt == DONE);
            imap_biu2arb_req <= (state_nxt == RUN);
            imap_biu2arb_vld <= (state_nxt == RUN) && (credit_nxt < CW'(MAX_OSTD));
            if (start_acc) begin
                total             <= start_total;
                iss_cnt           <= '0;
                imap_waddr        <= '0;
                imap_biu2arb_addr <= imap_base_addr;
            end else begin
                if (addr_hs) begin
                    iss_cnt           <= iss_cnt + 24'd1;
                    imap_biu2arb_addr <= imap_biu2arb_addr + STRIDE;
                end
                if (pop) imap_waddr <= imap_waddr + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < MAX_OSTD; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= arb2imap_biu_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

`ifdef IMAP_STREAM_BIU_ADDR_CHK_EN
    logic [ADDR_W-1:0] rsp_addr_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imap_err     <= 1'b0;
            rsp_addr_exp <= '0;
        end else if (start_acc) begin
            imap_err     <= 1'b0;
            rsp_addr_exp <= imap_base_addr;
        end else if (push) begin
            rsp_addr_exp <= rsp_addr_exp + STRIDE;
            if (arb2imap_biu_addr != rsp_addr_exp) imap_err <= 1'b1;
        end
    end
`else
    logic unused_rsp_addr;
    assign unused_rsp_addr = ^arb2imap_biu_addr;
    assign imap_err        = 1'b0;
`endif

endmodule

// File: tb/tb_imap_stream_biu.sv
// Randomised self-checking bench for imap_stream_biu: memory responder with programmable
// latency, handshake monitor, and per-scenario checks against an address/data model.
module tb_imap_stream_biu;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int OSTD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imap_start = 1'b0;
    logic          imap_done, imap_busy;
    logic [7:0]    in_ch = '0;
    logic [15:0]   map_size = '0;
    logic [AW-1:0] imap_base_addr = '0;
    logic          imap_biu2arb_req, imap_biu2arb_vld;
    logic [AW-1:0] imap_biu2arb_addr;
    logic          imap_biu2arb_rdy = 1'b1;
    logic [AW-1:0] arb2imap_biu_addr = '0;
    logic [DW-1:0] arb2imap_biu_data = '0;
    logic          arb2imap_biu_vld = 1'b0;
    logic          arb2imap_biu_rdy;
    logic [23:0]   imap_waddr;
    logic [DW-1:0] imap_wdata;
    logic          imap_wen;
    logic          imap_wrdy = 1'b1;
    logic          imap_err;

    imap_stream_biu #(.DATA_W(DW), .ADDR_W(AW), .MAX_OSTD(OSTD)) dut (
        .clk(clk), .rst(rst), .imap_start(imap_start), .imap_done(imap_done), .imap_busy(imap_busy),
        .in_ch(in_ch), .map_size(map_size), .imap_base_addr(imap_base_addr),
        .imap_biu2arb_req(imap_biu2arb_req), .imap_biu2arb_addr(imap_biu2arb_addr),
        .imap_biu2arb_vld(imap_biu2arb_vld), .imap_biu2arb_rdy(imap_biu2arb_rdy),
        .arb2imap_biu_addr(arb2imap_biu_addr), .arb2imap_biu_data(arb2imap_biu_data),
        .arb2imap_biu_vld(arb2imap_biu_vld), .arb2imap_biu_rdy(arb2imap_biu_rdy),
        .imap_waddr(imap_waddr), .imap_wdata(imap_wdata), .imap_wen(imap_wen),
        .imap_wrdy(imap_wrdy), .imap_err(imap_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Knobs written by the scenario tasks, read by the responder/monitor.
    int          rsp_lat = 1, wrdy_mode = 0, corrupt_idx = -1;
    bit          arb_rdy_rand = 1'b0;
    logic [31:0] salt = 32'h0;

    // Scoreboard owned by the monitor; cleared on an accepted start.
    logic [31:0] pq_addr[$];
    int          pq_t[$];
    logic [31:0] obs_addr[$], obs_wdata[$];
    logic [23:0] obs_waddr[$];
    int issued = 0, written = 0, max_credit = 0, done_cnt = 0, done_cyc = -1, last_w_cyc = -1;
    int first_ahs_cyc = -1, last_ahs_cyc = -1, vld_seen = 0, req_seen = 0, wen_seen = 0, stab_err = 0;
    int rsp_cnt = 0, iss_at_first_rsp = -1, corrupt_cyc = -1, err_rise_cyc = -1, err_at_done = -1;
    logic prev_vstall = 1'b0, prev_wstall = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [23:0] prev_waddr = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
        return base + 32'(i) * 32'd4;
    endfunction

    // Memory responder: returns in issue order, rsp_lat cycles after the address handshake.
    always @(posedge clk) begin
        #1;
        if (pq_addr.size() > 0 && pq_t[0] <= cyc) begin
            arb2imap_biu_vld  = 1'b1;
            arb2imap_biu_data = memfn(pq_addr[0]);
            arb2imap_biu_addr = (rsp_cnt == corrupt_idx) ? 32'hDEAD_0000 : pq_addr[0];
        end else begin
            arb2imap_biu_vld = 1'b0;
        end
        imap_wrdy        = (wrdy_mode == 0) ? 1'b1 : (wrdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        imap_biu2arb_rdy = arb_rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Mid-cycle monitor: values seen here are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            prev_vstall = 1'b0; prev_wstall = 1'b0;
            issued = 0; written = 0; wen_seen = 0;
        end else begin
            if (imap_start && !imap_busy) begin
                obs_addr.delete(); obs_wdata.delete(); obs_waddr.delete();
                issued = 0; written = 0; max_credit = 0; done_cnt = 0; done_cyc = -1; last_w_cyc = -1;
                first_ahs_cyc = -1; last_ahs_cyc = -1; vld_seen = 0; req_seen = 0; wen_seen = 0;
                stab_err = 0; rsp_cnt = 0; iss_at_first_rsp = -1; corrupt_cyc = -1;
                err_rise_cyc = -1; err_at_done = -1;
            end
            if (imap_biu2arb_req) req_seen++;
            if (imap_biu2arb_vld) vld_seen++;
            if (imap_wen) wen_seen++;
            if (prev_vstall && (!imap_biu2arb_vld || imap_biu2arb_addr !== prev_addr)) stab_err++;
            if (prev_wstall && (!imap_wen || imap_wdata !== prev_wdata || imap_waddr !== prev_waddr)) stab_err++;
            prev_vstall = imap_biu2arb_vld && !imap_biu2arb_rdy;
            prev_wstall = imap_wen && !imap_wrdy;
            prev_addr = imap_biu2arb_addr; prev_wdata = imap_wdata; prev_waddr = imap_waddr;
            if (imap_biu2arb_vld && imap_biu2arb_rdy) begin
                obs_addr.push_back(imap_biu2arb_addr);
                pq_addr.push_back(imap_biu2arb_addr);
                pq_t.push_back(cyc + rsp_lat);
                issued++;
                if (first_ahs_cyc < 0) first_ahs_cyc = cyc;
                last_ahs_cyc = cyc;
            end
            if (imap_wen && imap_wrdy) begin
                obs_wdata.push_back(imap_wdata);
                obs_waddr.push_back(imap_waddr);
                written++;
                last_w_cyc = cyc;
            end
            if (issued - written > max_credit) max_credit = issued - written;
            if (imap_done) begin done_cnt++; done_cyc = cyc; err_at_done = int'(imap_err); end
            if (imap_err && err_rise_cyc < 0) err_rise_cyc = cyc;
        end
        if (arb2imap_biu_vld && arb2imap_biu_rdy && pq_addr.size() > 0) begin
            if (rsp_cnt == corrupt_idx) corrupt_cyc = cyc;
            if (iss_at_first_rsp < 0) iss_at_first_rsp = issued;
            void'(pq_addr.pop_front());
            void'(pq_t.pop_front());
            rsp_cnt++;
        end
    end

    int start_cyc;

    task automatic do_start(input logic [7:0] ch, input logic [15:0] ms, input logic [31:0] base);
        @(posedge clk); #1;
        in_ch = ch; map_size = ms; imap_base_addr = base; imap_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        imap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if ({imap_done, imap_busy, imap_biu2arb_req, imap_biu2arb_vld, imap_wen, imap_err, arb2imap_biu_rdy} !== 7'b0000001) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 0000001", {imap_done, imap_busy, imap_biu2arb_req,
                     imap_biu2arb_vld, imap_wen, imap_err, arb2imap_biu_rdy});
        end
        n_cmp++;
        if (imap_biu2arb_addr !== '0 || imap_waddr !== '0 || imap_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_data got addr=%h waddr=%h wdata=%h want 0", imap_biu2arb_addr, imap_waddr, imap_wdata);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (imap_busy !== 1'b0 || arb2imap_biu_rdy !== 1'b1) begin
            n_bad++; $display("FAIL reset_idle got busy=%b rdy=%b want 0/1", imap_busy, arb2imap_biu_rdy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        salt = $urandom; rsp_lat = 1; wrdy_mode = 0; arb_rdy_rand = 1'b0;
        do_start(8'd2, 16'd3, 32'h1000);
        @(negedge clk); #1;
        n_cmp++;
        if ({imap_busy, imap_biu2arb_req, imap_biu2arb_vld} !== 3'b111 || imap_biu2arb_addr !== 32'h1000) begin
            n_bad++;
            $display("FAIL basic_first got busy/req/vld=%b addr=%h want 111 1000",
                     {imap_busy, imap_biu2arb_req, imap_biu2arb_vld}, imap_biu2arb_addr);
        end
        // A start while busy must not re-sample the configuration.
        @(posedge clk); #1;
        imap_start = 1'b1; in_ch = 8'd9; map_size = 16'd9; imap_base_addr = 32'h8000;
        @(posedge clk); #1; imap_start = 1'b0;
        wait_done(200, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_timeout got no done want done"); end
        n_cmp++;
        if (obs_addr.size() != 6 || obs_wdata.size() != 6) begin
            n_bad++; $display("FAIL basic_count got addr=%0d wr=%0d want 6/6", obs_addr.size(), obs_wdata.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 6; i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr(32'h1000, i)) begin
                n_bad++; $display("FAIL basic_addr[%0d] got %h want %h", i, obs_addr[i], exp_addr(32'h1000, i));
            end
        end
        for (int i = 0; i < obs_wdata.size() && i < 6; i++) begin
            n_cmp++;
            if (obs_wdata[i] !== memfn(exp_addr(32'h1000, i)) || obs_waddr[i] !== 24'(i)) begin
                n_bad++;
                $display("FAIL basic_write[%0d] got %h@%0d want %h@%0d", i, obs_wdata[i], obs_waddr[i],
                         memfn(exp_addr(32'h1000, i)), i);
            end
        end
        n_cmp++;
        if (last_ahs_cyc - first_ahs_cyc != 5 || first_ahs_cyc != start_cyc + 1) begin
            n_bad++;
            $display("FAIL basic_b2b got span=%0d first=T+%0d want 5 T+1", last_ahs_cyc - first_ahs_cyc,
                     first_ahs_cyc - start_cyc);
        end
        n_cmp++;
        if (done_cyc != last_w_cyc + 1) begin
            n_bad++; $display("FAIL basic_done_time got W+%0d want W+1", done_cyc - last_w_cyc);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (imap_busy !== 1'b0 || done_cnt != 1) begin
            n_bad++; $display("FAIL basic_end got busy=%b done_cnt=%0d want 0 1", imap_busy, done_cnt);
        end
    endtask

    task automatic test_zero();
        for (int k = 0; k < 2; k++) begin
            do_start((k == 0) ? 8'd0 : 8'd3, (k == 0) ? 16'd5 : 16'd0, $urandom);
            imap_start = 1'b1; in_ch = 8'd1; map_size = 16'd1;
            @(negedge clk); #1;
            n_cmp++;
            if ({imap_done, imap_busy} !== 2'b11) begin
                n_bad++; $display("FAIL zero%0d_done got done/busy=%b want 11", k, {imap_done, imap_busy});
            end
            @(posedge clk); #1; imap_start = 1'b0;
            repeat (4) @(negedge clk); #1;
            n_cmp++;
            if (imap_busy !== 1'b0 || req_seen != 0 || vld_seen != 0 || done_cnt != 1) begin
                n_bad++;
                $display("FAIL zero%0d_quiet got busy=%b req=%0d vld=%0d done=%0d want 0 0 0 1", k, imap_busy,
                         req_seen, vld_seen, done_cnt);
            end
        end
    endtask

    task automatic test_outstanding();
        bit ok;
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        salt = $urandom; rsp_lat = 20; wrdy_mode = 0;
        do_start(8'd2, 16'd5, base);
        wait_done(500, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ostd_timeout got no done want done"); end
        n_cmp++;
        if (iss_at_first_rsp != OSTD || max_credit != OSTD) begin
            n_bad++;
            $display("FAIL ostd_limit got first=%0d max=%0d want %0d %0d", iss_at_first_rsp, max_credit, OSTD, OSTD);
        end
        n_cmp++;
        if (obs_wdata.size() != 10) begin n_bad++; $display("FAIL ostd_count got %0d want 10", obs_wdata.size()); end
        for (int i = 0; i < obs_wdata.size() && i < 10; i++) begin
            n_cmp++;
            if (obs_wdata[i] !== memfn(exp_addr(base, i)) || obs_waddr[i] !== 24'(i)) begin
                n_bad++; $display("FAIL ostd_write[%0d] got %h want %h", i, obs_wdata[i], memfn(exp_addr(base, i)));
            end
        end
        rsp_lat = 1;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] base;
        base = $urandom;
        salt = $urandom; rsp_lat = 1; wrdy_mode = 2;
        do_start(8'd1, 16'd10, base);
        repeat (14) @(negedge clk); #1;
        n_cmp++;
        if (issued != OSTD || written != 0 || imap_biu2arb_vld !== 1'b0 || imap_wen !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall got iss=%0d wr=%0d vld=%b wen=%b want %0d 0 0 1", issued, written,
                     imap_biu2arb_vld, imap_wen, OSTD);
        end
        wrdy_mode = 0;
        wait_done(300, ok);
        n_cmp++;
        if (!ok || obs_wdata.size() != 10 || stab_err != 0 || max_credit > OSTD) begin
            n_bad++;
            $display("FAIL bp_resume got ok=%0b wr=%0d stab=%0d maxc=%0d want 1 10 0 <=%0d", ok, obs_wdata.size(),
                     stab_err, max_credit, OSTD);
        end
        for (int i = 0; i < obs_wdata.size() && i < 10; i++) begin
            n_cmp++;
            if (obs_wdata[i] !== memfn(exp_addr(base, i)) || obs_waddr[i] !== 24'(i)) begin
                n_bad++; $display("FAIL bp_write[%0d] got %h want %h", i, obs_wdata[i], memfn(exp_addr(base, i)));
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int total, bad;
        logic [31:0] base;
        for (int it = 0; it < 6; it++) begin
            logic [7:0]  ch;
            logic [15:0] ms;
            ch = 8'($urandom_range(1, 3));
            ms = 16'($urandom_range(1, 12));
            base = (it == 0) ? 32'hFFFF_FFF0 : $urandom;
            total = int'(ch) * int'(ms);
            salt = $urandom; rsp_lat = $urandom_range(1, 8); wrdy_mode = 1; arb_rdy_rand = 1'b1;
            do_start(ch, ms, base);
            wait_done(3000, ok);
            n_cmp++;
            if (!ok || obs_addr.size() != total || obs_wdata.size() != total) begin
                n_bad++;
                $display("FAIL rand%0d_count got ok=%0b addr=%0d wr=%0d want 1 %0d %0d", it, ok, obs_addr.size(),
                         obs_wdata.size(), total, total);
            end
            bad = 0;
            for (int i = 0; i < obs_wdata.size() && i < obs_addr.size(); i++) begin
                if (obs_addr[i] !== exp_addr(base, i) || obs_wdata[i] !== memfn(exp_addr(base, i)) ||
                    obs_waddr[i] !== 24'(i)) bad++;
            end
            n_cmp++;
            if (bad != 0) begin n_bad++; $display("FAIL rand%0d_stream got %0d bad words want 0", it, bad); end
            n_cmp++;
            if (max_credit > OSTD || stab_err != 0 || done_cyc != last_w_cyc + 1) begin
                n_bad++;
                $display("FAIL rand%0d_proto got maxc=%0d stab=%0d done=W+%0d want <=%0d 0 W+1", it, max_credit,
                         stab_err, done_cyc - last_w_cyc, OSTD);
            end
        end
        wrdy_mode = 0; arb_rdy_rand = 1'b0; rsp_lat = 1;
    endtask

    task automatic test_reset_restart();
        bit ok;
        logic [31:0] base;
        salt = $urandom; rsp_lat = 30; wrdy_mode = 0;
        do_start(8'd1, 16'd8, $urandom);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (issued == 3) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1; rst = 1'b1; #1;
        n_cmp++;
        if (!ok || {imap_busy, imap_biu2arb_req, imap_biu2arb_vld, imap_wen, imap_done} !== 5'b0 ||
            imap_biu2arb_addr !== '0 || imap_waddr !== '0 || arb2imap_biu_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_clear got ok=%0b ctrl=%b addr=%h waddr=%h rdy=%b want 1 00000 0 0 1", ok,
                     {imap_busy, imap_biu2arb_req, imap_biu2arb_vld, imap_wen, imap_done}, imap_biu2arb_addr,
                     imap_waddr, arb2imap_biu_rdy);
        end
        repeat (2) @(posedge clk); #1; rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (pq_addr.size() == 0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if (!ok || rsp_cnt != 3 || wen_seen != 0 || written != 0) begin
            n_bad++;
            $display("FAIL rr_drop got drained=%0b rsp=%0d wen=%0d wr=%0d want 1 3 0 0", ok, rsp_cnt, wen_seen,
                     written);
        end
        rsp_lat = 2; base = $urandom;
        do_start(8'd2, 16'd4, base);
        wait_done(300, ok);
        n_cmp++;
        if (!ok || obs_wdata.size() != 8) begin
            n_bad++; $display("FAIL rr_restart got ok=%0b wr=%0d want 1 8", ok, obs_wdata.size());
        end
        for (int i = 0; i < obs_wdata.size() && i < 8; i++) begin
            n_cmp++;
            if (obs_wdata[i] !== memfn(exp_addr(base, i)) || obs_waddr[i] !== 24'(i)) begin
                n_bad++; $display("FAIL rr_write[%0d] got %h want %h", i, obs_wdata[i], memfn(exp_addr(base, i)));
            end
        end
        rsp_lat = 1;
    endtask

    task automatic test_addr_chk();
        bit ok;
        logic [31:0] base;
        base = $urandom;
        salt = $urandom; rsp_lat = 1; wrdy_mode = 0; corrupt_idx = 2;
        do_start(8'd1, 16'd6, base);
        wait_done(200, ok);
        corrupt_idx = -1;
        n_cmp++;
        if (!ok || obs_wdata.size() != 6 || obs_wdata[2] !== memfn(exp_addr(base, 2))) begin
            n_bad++;
            $display("FAIL achk_data got ok=%0b wr=%0d want 1 6 with word 2 intact", ok, obs_wdata.size());
        end
`ifdef IMAP_STREAM_BIU_ADDR_CHK_EN
        n_cmp++;
        if (corrupt_cyc < 0 || err_rise_cyc != corrupt_cyc + 1 || err_at_done != 1) begin
            n_bad++;
            $display("FAIL achk_err got rise=R+%0d at_done=%0d want R+1 1", err_rise_cyc - corrupt_cyc, err_at_done);
        end
        do_start(8'd1, 16'd2, base);
        @(negedge clk); #1;
        n_cmp++;
        if (imap_err !== 1'b0) begin n_bad++; $display("FAIL achk_clear got err=%b want 0", imap_err); end
        wait_done(100, ok);
        n_cmp++;
        if (!ok || err_at_done != 0) begin
            n_bad++; $display("FAIL achk_clean got ok=%0b err_at_done=%0d want 1 0", ok, err_at_done);
        end
`else
        n_cmp++;
        if (err_rise_cyc != -1 || imap_err !== 1'b0) begin
            n_bad++; $display("FAIL achk_off got err=%b rise=%0d want 0 -1", imap_err, err_rise_cyc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_outstanding();
        test_backpressure();
        test_random();
        test_reset_restart();
        test_addr_chk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imap_stream_biu.md
# imap_stream_biu

Parametrised input-feature-map bus interface unit. On a start pulse it streams `in_ch*map_size` words from external memory through the bus arbiter, with up to `MAX_OSTD` reads in flight. Responses are buffered in an internal FIFO and written to the MAC array input buffer under ready/valid backpressure. It sits between the accelerator controller, the arbiter read port and the MAC array imap buffer.

## Interface
- `DATA_W`, 32: bus/write data width; power of two, ≥8.
- `ADDR_W`, 32: address width.
- `MAX_OSTD`, 4: maximum outstanding reads and FIFO depth; power of two, 2..16.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imap_start`  in  1  one-cycle start pulse; ignored unless IDLE.
- `imap_done`  out  1  one-cycle pulse when the last word has been written.
- `imap_busy`  out  1  high in any state other than IDLE.
- `in_ch`  in  8  channel count; sampled on the accepted start.
- `map_size`  in  16  words per channel; sampled on the accepted start.
- `imap_base_addr`  in  ADDR_W  byte base address; sampled on the accepted start.
- `imap_biu2arb_req`  out  1  bus ownership request.
- `imap_biu2arb_addr`  out  ADDR_W  read byte address.
- `imap_biu2arb_vld` / `imap_biu2arb_rdy`  out/in  1  address handshake.
- `arb2imap_biu_addr`  in  ADDR_W  response address.
- `arb2imap_biu_data`  in  DATA_W  response data.
- `arb2imap_biu_vld` / `arb2imap_biu_rdy`  in/out  1  response handshake.
- `imap_waddr`  out  24  word index into the MAC imap buffer.
- `imap_wdata`  out  DATA_W  write data.
- `imap_wen` / `imap_wrdy`  out/in  1  write handshake; a write occurs when both are high.
- `imap_err`  out  1  sticky response-order error (see Configuration).

## Operation
- Word count: `total = in_ch*map_size`, computed as 24-bit unsigned. Word address: `base + idx*(DATA_W/8)`, wrapping modulo 2^ADDR_W.
- States:
  - IDLE: an accepted start latches the config. If `total==0`, go to DONE; otherwise go to RUN.
  - RUN: issue addresses and drain responses. When the last address is accepted, go to DRAIN.
  - DRAIN: drain only. When the write count reaches `total`, go to DONE.
  - DONE: `imap_done` is high for one cycle, then go to IDLE.
- Credit counter:
  - `credit` holds reads not yet written out (issued but unreturned, plus FIFO occupancy).
  - It increments on an address handshake and decrements on an `imap_wen&imap_wrdy` write.
  - If both events occur in the same cycle, `credit` is unchanged.
- `imap_biu2arb_vld = (state==RUN) && credit<MAX_OSTD`.
- `imap_biu2arb_req` is high throughout RUN.
- `addr` and `vld` are registered. They hold stable while `vld&!rdy`.
- Response FIFO:
  - Depth MAX_OSTD, show-ahead.
  - `arb2imap_biu_rdy = !fifo_full` in RUN/DRAIN and 1 in IDLE/DONE. Responses accepted in IDLE/DONE are discarded.
  - The credit scheme guarantees no overflow.
  - A simultaneous push and pop keeps the count unchanged.
- Write side:
  - `imap_wen = !fifo_empty`; `imap_wdata` is the FIFO head; `imap_waddr` is the running write index (0..total-1).
  - Data and address hold stable while `wen&!wrdy`.
- Responses must return in issue order.
- `rst` mid-operation: all state is cleared immediately and the block enters IDLE. Late responses are then discarded.

## Timing
- Reset values:
  - `imap_done`, `imap_busy`, `req`, `vld`, `imap_wen`, `imap_err` = 0.
  - `addr`, `waddr`, `wdata` = 0.
  - `arb2imap_biu_rdy` = 1.
- Start accepted in cycle T: `busy`, `req` and `vld` are high in T+1, with the first address equal to base.
- Back-to-back addresses: one per cycle while `rdy` is high and credit is available.
- Response accepted in cycle R: `imap_wen` is high in R+1.
- Last write handshake in cycle W: DONE, with `imap_done` high, in W+1; `busy` is low in W+2.
- `total==0`: `imap_done` is high in T+1, with no bus activity.
- A start while busy (including in DONE) is ignored, and the config is not re-sampled.

## Configuration
- `IMAP_STREAM_BIU_ADDR_CHK_EN` defined:
  - Each accepted response address is compared against the expected next address (`base + rsp_idx*(DATA_W/8)`).
  - A mismatch sets `imap_err`. It stays set until the next accepted start or `rst`.
  - The data is still written.
- Undefined:
  - `imap_err` is tied to 0.
  - `arb2imap_biu_addr` is ignored.
  - No comparator or response index register is built.

## Test plan
- Basic transfer: `DATA_W=32`, `in_ch=2`, `map_size=3`, `base=0x1000`, with `arb rdy` and `wrdy` always 1 and 1-cycle response latency.
  - Addresses are 0x1000, 0x1004 … 0x1014.
  - Six writes occur with `waddr` 0..5 and data in order.
  - `imap_done` pulses once, one cycle after the 6th write.
- Outstanding limit: `MAX_OSTD=4`, responses delayed 20 cycles, 10 words.
  - Exactly 4 address handshakes occur before the first response.
  - `credit` never exceeds 4.
- Write backpressure: `wrdy` held at 0 for 15 cycles.
  - The FIFO fills to 4; `vld` stays low and `arb rdy` stays high.
  - No data is lost, and writes resume in order when `wrdy` rises.
- Zero size: `in_ch=0` (and separately `map_size=0`).
  - `imap_done` is high at T+1, and `req`/`vld` are never asserted.
- Reset and restart: `rst` asserted mid-RUN with 3 reads outstanding.
  - Outputs return to reset values at once.
  - The 3 late responses are accepted and dropped with no `wen`.
  - A new start then completes normally.
- Address check (macro defined): the 3rd response address is corrupted to 0xDEAD0000.
  - `imap_err` rises the cycle after that response and stays set through `done`.
  - The next accepted start clears it.
